// File: rtl/osd_trace_depacketization.sv
// Trace-event DII depacketizer: rebuilds one trace word or one overflow
// status record from each incoming packet of 16-bit flits, and drops
// packets with a bad destination, header, status flit or length.

package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

// state   | meaning
// --------+------------------------------------------------------------
// DEST    | waiting for the destination flit of a new packet
// SOURCE  | waiting for the header flit (type, overflow, source id)
// STATUS  | waiting for the single overflow-count flit
// PAYLOAD | collecting trace word flits, counter selects the slice
// DROP    | discarding the rest of a malformed packet up to its last flit
// OUTPUT  | record presented on trace_*, waiting for trace_ready
module osd_trace_depacketization #(
  parameter int WIDTH      = 40,
  parameter bit CHECK_DEST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            id,
  input  dii_package::dii_flit   debug_in,
  output logic                   debug_in_ready,
  output logic [WIDTH-1:0]       trace_data,
  output logic                   trace_overflow,
  output logic [9:0]             trace_src_id,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic                   err_drop
);

  localparam int NUM_FLITS = (WIDTH + 15) / 16;
  localparam int CW        = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_FLITS - 1);

  typedef enum logic [2:0] {
    DEST    = 3'd0,
    SOURCE  = 3'd1,
    STATUS  = 3'd2,
    PAYLOAD = 3'd3,
    DROP    = 3'd4,
    OUTPUT  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     counter;
  logic [CW-1:0]     counter_next;
  logic              err_next;
  logic              hdr_load;
  logic              status_load;
  logic              payload_load;
  logic              accept;
  logic              hdr_ok;
  logic [WIDTH-1:0]  payload_merge;

  // Every state except OUTPUT takes flits; OUTPUT holds the record.
  assign debug_in_ready = (state != OUTPUT);
  assign trace_valid    = (state == OUTPUT);
  assign accept         = debug_in.valid && debug_in_ready;

  // Header must be an event packet (type 2'b10) and not a bulk transfer.
  assign hdr_ok = (debug_in.data[15:14] == 2'b10) && !debug_in.data[10];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= DEST;
    else     state <= state_next;
  end

  // Next-state decode and datapath load strobes.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    err_next     = 1'b0;
    hdr_load     = 1'b0;
    status_load  = 1'b0;
    payload_load = 1'b0;
    case (state)
      DEST: begin
        if (accept) begin
          if (debug_in.last) begin
            err_next = 1'b1;
          end else if (CHECK_DEST && (debug_in.data != id)) begin
            state_next = DROP;
          end else begin
            state_next = SOURCE;
          end
        end
      end
      SOURCE: begin
        if (accept) begin
          if (!hdr_ok) begin
            if (debug_in.last) begin
              err_next   = 1'b1;
              state_next = DEST;
            end else begin
              state_next = DROP;
            end
          end else begin
            hdr_load     = 1'b1;
            counter_next = '0;
            if (debug_in.last) begin
              err_next   = 1'b1;
              state_next = DEST;
            end else if (debug_in.data[11]) begin
              state_next = STATUS;
            end else begin
              state_next = PAYLOAD;
            end
          end
        end
      end
      STATUS: begin
        if (accept) begin
          if (debug_in.last && debug_in.data[15]) begin
            status_load = 1'b1;
            state_next  = OUTPUT;
          end else if (debug_in.last) begin
            err_next   = 1'b1;
            state_next = DEST;
          end else begin
            state_next = DROP;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          payload_load = 1'b1;
          if (debug_in.last && (counter < LAST_IDX)) begin
            err_next   = 1'b1;
            state_next = DEST;
          end else if (counter == LAST_IDX) begin
            // Counter saturates here: a missing last flag means a long packet.
            state_next = debug_in.last ? OUTPUT : DROP;
          end else begin
            counter_next = counter + 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && debug_in.last) begin
          err_next   = 1'b1;
          state_next = DEST;
        end
      end
      OUTPUT: begin
        if (trace_ready) state_next = DEST;
      end
      default: state_next = DEST;
    endcase
  end

  // Merge the current flit into its slice; bits past WIDTH on the final
  // flit fall outside the loop and are silently ignored.
  always_comb begin
    payload_merge = trace_data;
    for (int b = 0; b < WIDTH; b++) begin
      if (counter == CW'(b / 16)) payload_merge[b] = debug_in.data[4'(b % 16)];
    end
  end

  // Datapath registers: counter, error pulse and the output record.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter        <= '0;
      err_drop       <= 1'b0;
      trace_data     <= '0;
      trace_overflow <= 1'b0;
      trace_src_id   <= '0;
    end else begin
      counter  <= counter_next;
      err_drop <= err_next;
      if (hdr_load) begin
        trace_src_id   <= debug_in.data[9:0];
        trace_overflow <= debug_in.data[11];
      end
      if (status_load)       trace_data <= WIDTH'(debug_in.data[9:0]);
      else if (payload_load) trace_data <= payload_merge;
    end
  end

endmodule
